// File: rtl/mysoc_sysid_checker.sv
// mysoc_sysid_checker
//
// Avalon-MM read master for the system-ID slave. It reads word 0 (system
// ID) and then word 1 (build timestamp). It compares each word against its
// expected value and reports match, mismatch or bus timeout to the boot and
// status logic.
//
// Ports
//   clock            single clock; all logic on the rising edge
//   reset            synchronous, active-high reset
//   start            launch a check sequence (honoured in IDLE/DONE only)
//   avm_address      word address to the slave (0 = ID, 1 = timestamp)
//   avm_read         read strobe
//   avm_readdata     read data from the slave
//   avm_waitrequest  slave stall
//   busy             sequence in progress (RD_ID, RD_TS, CHECK)
//   done             results valid; level, held until next launch or reset
//   id_ok / ts_ok    captured word equals the expected value
//   timeout          a read stalled for TIMEOUT_CYCLES cycles and was aborted
//   id_value         captured word 0
//   ts_value         captured word 1
//   fsm_state        current FSM state, for debug and checkers
//
// Handshake: a read is outstanding for as long as avm_read=1. The slave
// completes it in the cycle where avm_waitrequest=0, and avm_readdata is
// taken on that edge. While avm_waitrequest=1, avm_read and avm_address
// hold unchanged, unless the wait counter aborts the read.
//
// Every output comes from a register. The always_comb block only computes
// the next register values.
module mysoc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h623B_2E61,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        first_q;
    logic        launch;
    logic        avm_address_d, avm_read_d, busy_d, done_d;
    logic        id_ok_d, ts_ok_d, timeout_d;
    logic [31:0] id_value_d, ts_value_d;

    // first_q is high only in the first cycle after reset is released.
    // AUTO_START uses it to launch one sequence without a start pulse.
    assign launch    = start || (AUTO_START && first_q);
    assign fsm_state = state_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        avm_address_d = avm_address;
        avm_read_d    = avm_read;
        busy_d        = busy;
        done_d        = done;
        id_ok_d       = id_ok;
        ts_ok_d       = ts_ok;
        timeout_d     = timeout;
        id_value_d    = id_value;
        ts_value_d    = ts_value;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d       = ST_RD_ID;
                    wait_cnt_d    = '0;
                    avm_address_d = 1'b0;
                    avm_read_d    = 1'b1;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_d     = 1'b0;
                end
            end

            ST_RD_ID, ST_RD_TS: begin
                // An exhausted wait budget wins, even if the slave
                // answers in that same cycle.
                if (wait_cnt_q == TIMEOUT_LIM) begin
                    state_d    = ST_DONE;
                    avm_read_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                end else if (!avm_waitrequest) begin
                    wait_cnt_d = '0;
                    if (state_q == ST_RD_ID) begin
                        id_value_d    = avm_readdata;
                        avm_address_d = 1'b1;
                        state_d       = ST_RD_TS;
                    end else begin
                        ts_value_d = avm_readdata;
                        avm_read_d = 1'b0;
                        state_d    = ST_CHECK;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            ST_CHECK: begin
                id_ok_d = (id_value == EXPECTED_ID);
                ts_ok_d = (ts_value == EXPECTED_TS);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end

            default: begin
                state_d    = ST_IDLE;
                avm_read_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            first_q     <= 1'b1;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            first_q     <= 1'b0;
            avm_address <= avm_address_d;
            avm_read    <= avm_read_d;
            busy        <= busy_d;
            done        <= done_d;
            id_ok       <= id_ok_d;
            ts_ok       <= ts_ok_d;
            timeout     <= timeout_d;
            id_value    <= id_value_d;
            ts_value    <= ts_value_d;
        end
    end

endmodule

// File: tb/tb_mysoc_sysid_checker.sv
// Bench for mysoc_sysid_checker.
//
// The DUT runs with TIMEOUT_CYCLES=8 and AUTO_START=1. A behavioural slave
// answers each read after a configured number of stall cycles. The
// reference model gives the outcome of each sequence from the stall counts
// and the data words alone:
//   - a read times out when its stall count is >= T;
//   - otherwise the read completes after stall+1 cycles.
// Cycle numbering: the cycle in which start is sampled is cycle 0, so a
// zero-wait sequence shows done in cycle 4.
module tb_mysoc_sysid_checker;

    localparam int          T      = 8;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h623B_2E61;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] id_value, ts_value;
    logic [2:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    // slave configuration and model state
    logic [31:0] cfg_data [2];
    int          cfg_wait [2];
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    mysoc_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (T),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .fsm_state       (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural slave: it stalls each new read for cfg_wait cycles and
    // then returns cfg_data. It also checks that a stalled read is held
    // whenever the master cannot yet have aborted it.
    int   stall_cnt = 0;
    logic [1:0] prev_key = 2'b00;
    logic prev_wr = 1'b0, prev_addr = 1'b0, prev_rst = 1'b1;

    always @(negedge clock) begin
        if (prev_wr && !prev_rst && stall_cnt <= T) begin
            check("hold_read", {31'd0, avm_read}, 32'd1);
            check("hold_addr", {31'd0, avm_address}, {31'd0, prev_addr});
        end
        if ({avm_read, avm_address} != prev_key) stall_cnt = 0;
        prev_key = {avm_read, avm_address};
        if (avm_read && stall_cnt < cfg_wait[avm_address]) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            avm_waitrequest = 1'b0;
            avm_readdata    = avm_read ? cfg_data[avm_address] : $urandom();
        end
        prev_wr   = avm_read && avm_waitrequest;
        prev_addr = avm_address;
        prev_rst  = reset;
    end

    task automatic check_reset_values();
        check("rst_read",  {31'd0, avm_read}, 32'd0);
        check("rst_addr",  {31'd0, avm_address}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_id_ok", {31'd0, id_ok}, 32'd0);
        check("rst_ts_ok", {31'd0, ts_ok}, 32'd0);
        check("rst_to",    {31'd0, timeout}, 32'd0);
        check("rst_id",    id_value, 32'd0);
        check("rst_ts",    ts_value, 32'd0);
    endtask

    // Runs one sequence, launched by start or (use_start=0) by the auto
    // launch just after reset release. poke_start pulses start mid-sequence.
    task automatic run_seq(input bit use_start, input int w_id, input int w_ts,
                           input logic [31:0] d_id, input logic [31:0] d_ts,
                           input bit poke_start);
        int   k, exp_k;
        logic exp_to, exp_idok, exp_tsok;
        cfg_wait[0] = w_id; cfg_wait[1] = w_ts;
        cfg_data[0] = d_id; cfg_data[1] = d_ts;

        exp_to = 1'b0;
        if (w_id >= T) begin
            exp_to = 1'b1;
            exp_k  = T + 2;
        end else begin
            m_id = d_id;
            if (w_ts >= T) begin
                exp_to = 1'b1;
                exp_k  = w_id + T + 3;
            end else begin
                m_ts  = d_ts;
                exp_k = w_id + w_ts + 4;
            end
        end
        exp_idok = !exp_to && (m_id == EXP_ID);
        exp_tsok = !exp_to && (m_ts == EXP_TS);

        if (use_start) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        k = 1;
        check("busy_after_launch", {31'd0, busy}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        while (!done && k < 200) begin
            if (poke_start && k == 2) start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            k++;
        end
        check("latency", k, exp_k);
        check("timeout", {31'd0, timeout}, {31'd0, exp_to});
        check("id_ok", {31'd0, id_ok}, {31'd0, exp_idok});
        check("ts_ok", {31'd0, ts_ok}, {31'd0, exp_tsok});
        check("id_value", id_value, m_id);
        check("ts_value", ts_value, m_ts);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("read_at_done", {31'd0, avm_read}, 32'd0);

        // No second sequence may follow: done holds and the bus stays quiet.
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("done_held", {31'd0, done}, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("read_idle", {31'd0, avm_read}, 32'd0);
        check("id_value_held", id_value, m_id);
    endtask

    initial begin
        int w0, w1;
        logic [31:0] d0, d1;
        cfg_wait[0] = 0; cfg_wait[1] = 0;
        cfg_data[0] = EXP_ID; cfg_data[1] = EXP_TS;

        // Clock and reset.
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values();
        reset = 1'b0;

        // Auto-launched sequence, with a start pulse while busy.
        run_seq(1'b0, 0, 0, EXP_ID, EXP_TS, 1'b1);
        // Zero-wait start, then a timestamp that is one off.
        run_seq(1'b1, 0, 0, EXP_ID, EXP_TS, 1'b0);
        run_seq(1'b1, 0, 0, EXP_ID, 32'h623B_2E60, 1'b0);
        // Three stall cycles on each read.
        run_seq(1'b1, 3, 3, EXP_ID, EXP_TS, 1'b0);
        // Timestamp read stuck, then ID read stuck, then stall one short of T.
        run_seq(1'b1, 0, 50, 32'hDEAD_BEEF, EXP_TS, 1'b0);
        run_seq(1'b1, 50, 0, EXP_ID, EXP_TS, 1'b0);
        run_seq(1'b1, T - 1, T - 1, EXP_ID, EXP_TS, 1'b0);
        run_seq(1'b1, T, 0, EXP_ID, EXP_TS, 1'b0);

        // Reset while RD_TS is stalled.
        cfg_wait[0] = 0; cfg_wait[1] = 50;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !(avm_read && avm_address); i++) begin
            @(posedge clock); #1;
        end
        check("reached_rd_ts", {31'd0, avm_read && avm_address}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_values();
        m_id = '0; m_ts = '0;
        reset = 1'b0;
        run_seq(1'b0, 0, 0, EXP_ID, EXP_TS, 1'b0);

        // Random stall counts and data words.
        for (int n = 0; n < 25; n++) begin
            w0 = ($urandom_range(0, 3) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, 5);
            w1 = ($urandom_range(0, 3) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, 5);
            d0 = $urandom_range(0, 1) ? EXP_ID : $urandom();
            d1 = $urandom_range(0, 1) ? EXP_TS : $urandom();
            run_seq(1'b1, w0, w1, d0, d1, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mysoc_sysid_checker.md
# mysoc_sysid_checker

Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its `readdata`. After reset (or on a `start` pulse) it reads word 0 (system ID) and word 1 (build timestamp), compares each against parameterised expected values, and reports match, mismatch or bus timeout to boot/status logic. Software and the LED status path use its flags to refuse a mismatched hardware image.

## Interface
- `EXPECTED_ID`, 32'h0000_0000: value word 0 must return.
- `EXPECTED_TS`, 32'h623B_2E61 (1648045665): value word 1 must return.
- `TIMEOUT_CYCLES`, 255: maximum consecutive `avm_waitrequest` cycles per read before abort; range 1..65535.
- `AUTO_START`, 1: when 1, a check sequence launches automatically on the first cycle after reset deasserts.

- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch a check sequence; sampled in IDLE or DONE only, ignored while busy.
- `avm_address`  out  1  word address to system-ID slave (0 = ID, 1 = timestamp).
- `avm_read`  out  1  read strobe.
- `avm_readdata`  in  32  read data from slave.
- `avm_waitrequest`  in  1  slave stall; tie 0 for zero-wait slaves.
- `busy`  out  1  sequence in progress.
- `done`  out  1  results valid; level, held until next accepted start or reset.
- `id_ok`  out  1  captured ID equals `EXPECTED_ID`.
- `ts_ok`  out  1  captured timestamp equals `EXPECTED_TS`.
- `timeout`  out  1  a read exceeded `TIMEOUT_CYCLES`.
- `id_value`  out  32  captured word 0.
- `ts_value`  out  32  captured word 1.

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE: if `start`=1, or `AUTO_START`=1 and this is the first cycle after reset, go to RD_ID and clear `done`, `id_ok`, `ts_ok`, `timeout`, and the timeout counter.
- RD_ID: `avm_read`=1, `avm_address`=0. When `avm_waitrequest`=0, capture `avm_readdata` into `id_value`, clear the counter, and go to RD_TS.
- RD_TS: `avm_read`=1, `avm_address`=1. When `avm_waitrequest`=0, capture into `ts_value` and go to CHECK.
- Timeout: in RD_ID or RD_TS, a 16-bit counter increments on every cycle with `avm_waitrequest`=1. When it reaches `TIMEOUT_CYCLES`:
  - `avm_read` drops on the next cycle, `timeout`=1, `id_ok`=`ts_ok`=0, state goes to DONE.
  - Values not yet captured keep their prior contents.
- CHECK: register both comparisons into `id_ok`/`ts_ok` (full 32-bit equality) and go to DONE.
- DONE: `done`=1. `start`=1 restarts exactly as from IDLE.
- `busy`=1 in RD_ID, RD_TS and CHECK; 0 otherwise.
- `avm_read` is never asserted outside RD_ID/RD_TS. `avm_address` and `avm_read` hold stable while `avm_waitrequest`=1.
- Reset mid-sequence: everything returns to reset values on the next edge and the in-flight read is abandoned. With `AUTO_START`=1 a fresh sequence launches after reset releases.

## Timing
- Reset values: state IDLE, `avm_read`=0, `avm_address`=0, `busy`=0, `done`=0, `id_ok`=0, `ts_ok`=0, `timeout`=0, `id_value`=0, `ts_value`=0.
- All outputs are registered; no combinational path from `avm_readdata` or `avm_waitrequest` to any output.
- Zero-wait slave, `start` sampled at edge N:
  - RD_ID from N+1, RD_TS from N+2, CHECK from N+3, `done`=1 from N+4.
  - Total latency is 4 cycles.
- Each wait cycle adds one cycle to the corresponding read.
- Timeout path: `timeout` and `done` both rise exactly `TIMEOUT_CYCLES`+1 cycles after the read state is entered.
- `start` asserted while `busy`=1 has no effect, including any pending restart.

## Test plan
- Zero-wait slave returning 0 / 32'h623B2E61, `start` pulse → `done` rises 4 cycles later, `id_ok`=`ts_ok`=1, `timeout`=0, `id_value`=0, `ts_value`=32'h623B2E61.
- Slave returns 32'h623B2E60 for word 1 → `id_ok`=1, `ts_ok`=0, `done`=1.
- `avm_waitrequest` held 3 cycles on each read → `done` rises 10 cycles after start, both flags 1, address/read stable during stalls.
- `TIMEOUT_CYCLES`=8, waitrequest stuck on word 1 → `timeout`=1 and `done`=1 at cycle 9 of RD_TS, `avm_read`=0 thereafter, `id_ok`=`ts_ok`=0, `id_value` still captured.
- `AUTO_START`=1, reset released with no start → sequence runs unprompted; `start` pulsed mid-sequence is ignored (no second sequence).
- `reset` asserted during RD_TS → all outputs return to reset values next cycle, then auto sequence reruns and passes.
